// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types for the pixel scan sequencer: FSM state encoding and step decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } scan_state_t;

   // Wide enough for the largest step (8).
   localparam int STEP_W = 4;

   // Run-time subsample code -> grid stride: 0->1, 1->2, 2->4, 3->8.
   function automatic logic [STEP_W-1:0] step_decode(input logic [1:0] code);
      logic [STEP_W-1:0] stride;
      case (code)
         2'd0:    stride = 4'd1;
         2'd1:    stride = 4'd2;
         2'd2:    stride = 4'd4;
         default: stride = 4'd8;
      endcase
      return stride;
   endfunction

endpackage

// File: rtl/pixel_scan_sequencer_trigger.sv
// Raster trigger: compares vcount/hcount against the programmed position, emits a rising-edge pulse.
// Latency: trig_out is combinational in the first matching cycle; a match held N cycles gives one pulse.
// Backpressure: none; the raster counters free-run.
// Ports: clk_in/rst_in (sync, active-high), hcount_in/vcount_in raster position, trig_out one-cycle pulse.
module raster_trigger_detect #(
   parameter int HCOUNT_W = 10,
   parameter int VCOUNT_W = 11,
   parameter int TRIG_V   = 320,
   parameter int TRIG_H   = 0
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   output logic                trig_out
);

   logic match;
   logic match_q;

   assign match = (vcount_in == VCOUNT_W'(TRIG_V)) && (hcount_in == HCOUNT_W'(TRIG_H));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match;
      end
   end

   assign trig_out = match && !match_q;

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Scan sequencer: arms on a raster position, then walks a subsampled GRID_W x GRID_H grid in raster order.
// Latency: valid_out rises the cycle after the trigger match; one pixel per clock with ready_in held high.
// Backpressure: valid/ready; x/y/last hold until accepted, valid_out is registered (no path from ready_in).
// Ports: clk_in, rst_in (sync, active-high), enable_in, continuous_in, step_in, hcount_in, vcount_in,
//        ready_in; x_out, y_out, valid_out, last_out, blob_trigger_out, frame_done_out, busy_out, overrun_out.
module pixel_scan_sequencer
   import scan_pkg::*;
#(
   parameter int GRID_W   = 48,
   parameter int GRID_H   = 64,
   parameter int HCOUNT_W = 10,
   parameter int VCOUNT_W = 11,
   parameter int TRIG_V   = 320,
   parameter int TRIG_H   = 0,
   localparam int X_W     = $clog2(GRID_W),
   localparam int Y_W     = $clog2(GRID_H)
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                enable_in,
   input  logic                continuous_in,
   input  logic [1:0]          step_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                ready_in,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic                valid_out,
   output logic                last_out,
   output logic                blob_trigger_out,
   output logic                frame_done_out,
   output logic                busy_out,
   output logic                overrun_out
);

   // One extra bit over the coordinate so x+step never wraps back into range;
   // also never narrower than the stride itself.
   localparam int XS_W = (X_W + 1 > STEP_W) ? X_W + 1 : STEP_W;
   localparam int YS_W = (Y_W + 1 > STEP_W) ? Y_W + 1 : STEP_W;

   scan_state_t       state;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [STEP_W-1:0] step;
   logic              valid;
   logic              busy;
   logic              blob;
   logic              done;
   logic              overrun;

   logic              trig;
   logic [XS_W-1:0]   x_sum;
   logic [YS_W-1:0]   y_sum;
   logic              x_end;
   logic              y_end;

   raster_trigger_detect #(
      .HCOUNT_W (HCOUNT_W),
      .VCOUNT_W (VCOUNT_W),
      .TRIG_V   (TRIG_V),
      .TRIG_H   (TRIG_H)
   ) u_trig (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .trig_out  (trig)
   );

   assign x_sum = XS_W'(x) + XS_W'(step);
   assign y_sum = YS_W'(y) + YS_W'(step);
   assign x_end = (x_sum >= XS_W'(GRID_W));
   assign y_end = (y_sum >= YS_W'(GRID_H));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= IDLE;
         x       <= '0;
         y       <= '0;
         step    <= STEP_W'(1);
         valid   <= 1'b0;
         busy    <= 1'b0;
         blob    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         blob <= 1'b0;
         done <= 1'b0;
         if (!enable_in) begin
            // Abort from anywhere: no frame_done, overrun history discarded.
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= ARMED;
               end
               ARMED: begin
                  if (trig) begin
                     state <= SCAN;
                     valid <= 1'b1;
                     busy  <= 1'b1;
                     blob  <= 1'b1;
                     x     <= '0;
                     y     <= '0;
                     step  <= step_decode(step_in);
                  end
               end
               SCAN: begin
                  if (trig) begin
                     overrun <= 1'b1;
                  end
                  if (valid && ready_in) begin
                     if (x_end) begin
                        x <= '0;
                        if (y_end) begin
                           y     <= '0;
                           state <= DONE;
                           valid <= 1'b0;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end else begin
                           y <= y_sum[Y_W-1:0];
                        end
                     end else begin
                        x <= x_sum[X_W-1:0];
                     end
                  end
               end
               DONE: begin
                  x     <= '0;
                  y     <= '0;
                  state <= continuous_in ? ARMED : IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign x_out            = x;
   assign y_out            = y;
   assign valid_out        = valid;
   // Gated by valid so a wide latched step cannot flag "last" while idle.
   assign last_out         = valid && x_end && y_end;
   assign blob_trigger_out = blob;
   assign frame_done_out   = done;
   assign busy_out         = busy;
   assign overrun_out      = overrun;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench for pixel_scan_sequencer: vector table for arm/trigger/overrun, scoreboarded frame scans.
// Latency: outputs sampled #1 after posedge and on negedge.
// Backpressure: ready_in driven constant or random per cycle.
module tb_pixel_scan_sequencer;

   localparam int GW = 48;
   localparam int GH = 64;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        enable_in = 1'b0;
   logic        continuous_in = 1'b0;
   logic [1:0]  step_in = 2'd0;
   logic [9:0]  hcount_in = 10'd5;
   logic [10:0] vcount_in = 11'd0;
   logic        ready_in = 1'b0;
   logic [5:0]  x_out;
   logic [5:0]  y_out;
   logic        valid_out;
   logic        last_out;
   logic        blob_trigger_out;
   logic        frame_done_out;
   logic        busy_out;
   logic        overrun_out;

   always #5 clk = ~clk;

   pixel_scan_sequencer dut (
      .clk_in           (clk),
      .rst_in           (rst_in),
      .enable_in        (enable_in),
      .continuous_in    (continuous_in),
      .step_in          (step_in),
      .hcount_in        (hcount_in),
      .vcount_in        (vcount_in),
      .ready_in         (ready_in),
      .x_out            (x_out),
      .y_out            (y_out),
      .valid_out        (valid_out),
      .last_out         (last_out),
      .blob_trigger_out (blob_trigger_out),
      .frame_done_out   (frame_done_out),
      .busy_out         (busy_out),
      .overrun_out      (overrun_out)
   );

   typedef struct {
      logic [5:0] x;
      logic [5:0] y;
      logic       last;
   } pix_t;

   // exp = {valid, busy, blob, done, overrun, last, x[5:0], y[5:0]}
   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] step;
      logic       m;
      logic       rdy;
      logic [17:0] exp;
   } vec_t;

   localparam int NV = 12;
   vec_t vt [NV];

   pix_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   bit   sb_en = 1'b0;
   bit   hold_pend = 1'b0;
   logic [5:0] hold_x, hold_y;
   logic hold_last;
   int   xfer_cnt, blob_cnt, done_cnt;
   logic [5:0] last_x, last_y;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, en, input logic [1:0] step, input logic m, rdy,
                               input logic v, b, bl, d, o, input logic [5:0] x, y);
      vec_t r;
      r.rst = rst; r.en = en; r.step = step; r.m = m; r.rdy = rdy;
      r.exp = {v, b, bl, d, o, 1'b0, x, y};
      return r;
   endfunction

   task automatic set_match(input logic m);
      vcount_in = m ? 11'd320 : 11'd0;
      hcount_in = m ? 10'd0 : 10'd5;
   endtask

   // Expected pixel stream for one frame at stride s; last = bottom-right visited point.
   task automatic push_frame(input int s);
      pix_t p;
      int lx, ly;
      lx = ((GW - 1) / s) * s;
      ly = ((GH - 1) / s) * s;
      for (int yy = 0; yy < GH; yy += s) begin
         for (int xx = 0; xx < GW; xx += s) begin
            p.x = 6'(xx);
            p.y = 6'(yy);
            p.last = (xx == lx) && (yy == ly);
            sbq.push_back(p);
         end
      end
   endtask

   task automatic monitor();
      pix_t e;
      if (!sb_en || rst_in) begin
         hold_pend = 1'b0;
         return;
      end
      if (hold_pend)
         chk("hold_stable", {valid_out, last_out, x_out, y_out}, {1'b1, hold_last, hold_x, hold_y});
      hold_pend = valid_out && !ready_in && enable_in;
      hold_x = x_out;
      hold_y = y_out;
      hold_last = last_out;
      if (blob_trigger_out) begin
         blob_cnt++;
         chk("blob_first_pixel", {valid_out, x_out, y_out}, {1'b1, 12'd0});
      end
      if (frame_done_out) begin
         done_cnt++;
         chk("done_outputs", {valid_out, busy_out, x_out, y_out}, 32'd0);
      end
      if (valid_out && ready_in) begin
         xfer_cnt++;
         if (last_out) begin
            last_x = x_out;
            last_y = y_out;
         end
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got pixel x=%0d y=%0d, expected no pixel", x_out, y_out);
         end else begin
            e = sbq.pop_front();
            chk("pixel", {last_out, x_out, y_out}, {e.last, e.x, e.y});
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      xfer_cnt = 0;
      blob_cnt = 0;
      done_cnt = 0;
      last_x = '0;
      last_y = '0;
   endtask

   task automatic trig_pulse(input int n);
      set_match(1'b1);
      repeat (n) tick();
      set_match(1'b0);
   endtask

   task automatic wait_done(input int target, input int budget, input bit rnd);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         if (rnd) ready_in = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      ready_in = 1'b1;
      chk("frame_done_seen", 32'(done_cnt >= target), 32'd1);
   endtask

   initial begin
      // rst en step m rdy | valid busy blob done ovr x y
      vt[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // reset state
      vt[1]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0); // trigger in IDLE ignored
      vt[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vt[3]  = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0); // edge on ARMED entry: not seen
      vt[4]  = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0); // held match: no new edge
      vt[5]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vt[6]  = mk(0, 1, 2, 1, 0,  1, 1, 1, 0, 0, 0, 0); // trigger: scan starts, step 4
      vt[7]  = mk(0, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0); // held, step change ignored
      vt[8]  = mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
      vt[9]  = mk(0, 1, 0, 1, 0,  1, 1, 0, 0, 1, 0, 0); // trigger mid-scan: overrun
      vt[10] = mk(0, 1, 0, 0, 1,  1, 1, 0, 0, 1, 4, 0); // transfer uses latched step 4
      vt[11] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // disable: abort, overrun cleared

      clear_counts();
      for (int i = 0; i < NV; i++) begin
         rst_in = vt[i].rst;
         enable_in = vt[i].en;
         step_in = vt[i].step;
         set_match(vt[i].m);
         ready_in = vt[i].rdy;
         tick();
         chk($sformatf("vec%0d", i),
             {valid_out, busy_out, blob_trigger_out, frame_done_out, overrun_out, last_out, x_out, y_out},
             32'(vt[i].exp));
      end

      // 1: one-shot full frame, step 1, ready always high
      sb_en = 1'b1;
      continuous_in = 1'b0;
      step_in = 2'd0;
      ready_in = 1'b1;
      enable_in = 1'b1;
      tick();
      clear_counts();
      push_frame(1);
      trig_pulse(1);
      wait_done(1, 4000, 1'b0);
      chk("t1_xfers", 32'(xfer_cnt), 32'd3072);
      chk("t1_last_xy", {last_x, last_y}, {6'd47, 6'd63});
      chk("t1_blob_cnt", 32'(blob_cnt), 32'd1);
      chk("t1_sb_empty", 32'(sbq.size()), 32'd0);
      tick();
      chk("t1_idle_after", {valid_out, busy_out, overrun_out}, 32'd0);
      repeat (3) tick();
      chk("t1_single_done", 32'(done_cnt), 32'd1);

      // 2: same frame under random backpressure
      clear_counts();
      push_frame(1);
      trig_pulse(1);
      wait_done(1, 20000, 1'b1);
      chk("t2_xfers", 32'(xfer_cnt), 32'd3072);
      chk("t2_sb_empty", 32'(sbq.size()), 32'd0);
      repeat (3) tick();

      // 3: step 4
      clear_counts();
      step_in = 2'd2;
      push_frame(4);
      trig_pulse(1);
      wait_done(1, 1000, 1'b0);
      chk("t3_xfers", 32'(xfer_cnt), 32'd192);
      chk("t3_last_xy", {last_x, last_y}, {6'd44, 6'd60});
      chk("t3_sb_empty", 32'(sbq.size()), 32'd0);
      repeat (3) tick();

      // 4: continuous, two frames at step 8
      clear_counts();
      continuous_in = 1'b1;
      step_in = 2'd3;
      push_frame(8);
      trig_pulse(1);
      wait_done(1, 500, 1'b0);
      chk("t4_overrun_f1", 32'(overrun_out), 32'd0);
      push_frame(8);
      trig_pulse(1);
      wait_done(2, 500, 1'b0);
      chk("t4_xfers", 32'(xfer_cnt), 32'd96);
      chk("t4_overrun_f2", 32'(overrun_out), 32'd0);
      chk("t4_sb_empty", 32'(sbq.size()), 32'd0);
      continuous_in = 1'b0;
      repeat (3) tick();

      // 5: trigger mid-scan sets sticky overrun, scan unaffected
      clear_counts();
      step_in = 2'd1;
      push_frame(2);
      trig_pulse(1);
      repeat (100) tick();
      chk("t5_overrun_pre", 32'(overrun_out), 32'd0);
      trig_pulse(1);
      chk("t5_overrun_set", 32'(overrun_out), 32'd1);
      wait_done(1, 2000, 1'b0);
      chk("t5_xfers", 32'(xfer_cnt), 32'd768);
      chk("t5_overrun_sticky", 32'(overrun_out), 32'd1);
      chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
      enable_in = 1'b0;
      tick();
      chk("t5_overrun_clr", 32'(overrun_out), 32'd0);

      // 6: abort by enable at pixel 1000, then held match + reset mid-scan
      enable_in = 1'b1;
      step_in = 2'd0;
      tick();
      clear_counts();
      push_frame(1);
      trig_pulse(1);
      for (int n = 0; n < 2000 && xfer_cnt < 1000; n++) tick();
      chk("t6_reach_1000", 32'(xfer_cnt >= 1000), 32'd1);
      enable_in = 1'b0;
      tick();
      chk("t6_abort", {valid_out, busy_out, x_out, y_out}, 32'd0);
      repeat (20) tick();
      chk("t6_no_done", 32'(done_cnt), 32'd0);
      sbq.delete();

      enable_in = 1'b1;
      tick();
      clear_counts();
      push_frame(1);
      trig_pulse(5);
      repeat (3) tick();
      chk("t6_one_trigger", 32'(blob_cnt), 32'd1);
      chk("t6_scanning", 32'(valid_out), 32'd1);
      rst_in = 1'b1;
      tick();
      chk("t6_reset_mid", {valid_out, busy_out, last_out, blob_trigger_out, frame_done_out,
                           overrun_out, x_out, y_out}, 32'd0);
      rst_in = 1'b0;
      sbq.delete();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
